// File: rtl/pixel_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_layer_sequencer
// Description : Scans every layer register set for every pixel of a frame and
//               hands visible layers to the address calculation stage.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_layer_sequencer #(
    parameter int HOR_PIX    = 'd480,
    parameter int VER_PIX    = 'd272,
    parameter int NUM_LAYERS = 'd16,
    localparam int X_DEPTH   = $clog2(HOR_PIX),
    localparam int Y_DEPTH   = $clog2(VER_PIX),
    localparam int L_DEPTH   = $clog2(NUM_LAYERS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frameStart,
    output logic [L_DEPTH-1:0] layerRegAddr,
    input  logic [127:0]       layerRegData,
    output logic [127:0]       layerRegisters,
    output logic [X_DEPTH:0]   xPixel,
    output logic [Y_DEPTH:0]   yPixel,
    output logic [L_DEPTH-1:0] layerIndex,
    output logic               newCalculation,
    input  logic               calcRdy,
    input  logic               stall,
    output logic               resultValid,
    output logic               busy,
    output logic               frameDone
);

    localparam logic [X_DEPTH:0]   C_X_MAX = (X_DEPTH+1)'(HOR_PIX - 1);
    localparam logic [Y_DEPTH:0]   C_Y_MAX = (Y_DEPTH+1)'(VER_PIX - 1);
    localparam logic [L_DEPTH-1:0] C_L_MAX = L_DEPTH'(NUM_LAYERS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_ISSUE   = 3'd2,
        S_WAIT    = 3'd3,
        S_ADVANCE = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [X_DEPTH:0]     r_x;
    logic [Y_DEPTH:0]     r_y;
    logic [L_DEPTH-1:0]   r_layer;
    logic [127:0]         r_layer_regs;
    logic                 r_frame_done;

    logic                 w_visible;
    logic                 w_last_layer;
    logic                 w_last_x;
    logic                 w_last_y;
    logic                 w_frame_end;
    logic                 w_new_calc;
    logic                 w_result_valid;

    // A layer is visible only when both its enable and its on-screen bit are set.
    assign w_visible    = layerRegData[0] & layerRegData[2];
    assign w_last_layer = (r_layer == C_L_MAX);
    assign w_last_x     = (r_x == C_X_MAX);
    assign w_last_y     = (r_y == C_Y_MAX);
    assign w_frame_end  = (r_state == S_ADVANCE) && w_last_layer && w_last_x && w_last_y;

    always_comb begin
        w_next_state   = r_state;
        w_new_calc     = 1'b0;
        w_result_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frameStart) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                w_next_state = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_visible) begin
                    w_new_calc   = 1'b1;
                    w_next_state = S_WAIT;
                end else begin
                    w_next_state = S_ADVANCE;
                end
            end
            S_WAIT: begin
                // calcRdy is only looked at here, never in the issue cycle.
                if (calcRdy && !stall) begin
                    w_result_valid = 1'b1;
                    w_next_state   = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (w_last_layer && w_last_x && w_last_y) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_FETCH;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x          <= '0;
            r_y          <= '0;
            r_layer      <= '0;
            r_layer_regs <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            case (r_state)
                S_IDLE: begin
                    if (frameStart) begin
                        r_x     <= '0;
                        r_y     <= '0;
                        r_layer <= '0;
                    end
                end
                S_ISSUE: begin
                    r_layer_regs <= layerRegData;
                end
                S_ADVANCE: begin
                    // Layer is the fastest counter, then x, then y.
                    if (w_last_layer) begin
                        r_layer <= '0;
                        if (w_last_x) begin
                            r_x <= '0;
                            if (w_last_y) begin
                                r_y <= '0;
                            end else begin
                                r_y <= r_y + (Y_DEPTH+1)'(1);
                            end
                        end else begin
                            r_x <= r_x + (X_DEPTH+1)'(1);
                        end
                    end else begin
                        r_layer <= r_layer + L_DEPTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign layerRegAddr   = r_layer;
    assign layerIndex     = r_layer;
    assign xPixel         = r_x;
    assign yPixel         = r_y;
    assign layerRegisters = r_layer_regs;
    assign newCalculation = w_new_calc;
    assign resultValid    = w_result_valid;
    assign busy           = (r_state != S_IDLE);
    assign frameDone      = r_frame_done;

endmodule
`default_nettype wire

// File: doc/pixel_layer_sequencer.md
PIXEL_LAYER_SEQUENCER -- requirements
Module: pixel_layer_sequencer

Interface
REQ-001 SHALL have parameter HOR_PIX, default 'd480, meaning screen width in pixels.
REQ-002 SHALL have parameter VER_PIX, default 'd272, meaning screen height in pixels.
REQ-003 SHALL have parameter NUM_LAYERS, default 'd16, meaning number of layer register sets scanned per pixel.
REQ-004 SHALL derive X_DEPTH=$clog2(HOR_PIX), Y_DEPTH=$clog2(VER_PIX) and L_DEPTH=$clog2(NUM_LAYERS) as localparams.
REQ-005 SHALL have port clk, input, 1, single clock of 50 MHz max.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port frameStart, input, 1, a high level in IDLE starts a frame scan.
REQ-008 SHALL have port layerRegAddr, output, L_DEPTH, layer register file read index.
REQ-009 SHALL have port layerRegData, input, 128, register file read data, valid one cycle after layerRegAddr.
REQ-010 SHALL have port layerRegisters, output, 128, latched layer registers for the address calculation stage.
REQ-011 SHALL have port xPixel, output, X_DEPTH+1, current pixel x.
REQ-012 SHALL have port yPixel, output, Y_DEPTH+1, current pixel y.
REQ-013 SHALL have port layerIndex, output, L_DEPTH, layer currently presented.
REQ-014 SHALL have port newCalculation, output, 1, one-cycle start pulse to the address calculation stage.
REQ-015 SHALL have port calcRdy, input, 1, address calculation stage ready/complete.
REQ-016 SHALL have port stall, input, 1, downstream back-pressure.
REQ-017 SHALL have port resultValid, output, 1, one-cycle pulse marking a completed visible-layer calculation.
REQ-018 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-019 SHALL have port frameDone, output, 1, one-cycle pulse after the last layer of the last pixel.

Function
REQ-020 SHALL implement states IDLE, FETCH, ISSUE, WAIT, ADVANCE.
REQ-021 IDLE: on frameStart=1 SHALL clear x, y and layer counters and go to FETCH; otherwise SHALL remain in IDLE.
REQ-022 FETCH: layerRegAddr SHALL equal layerIndex; go to ISSUE next cycle.
REQ-023 ISSUE: SHALL latch layerRegData into layerRegisters; if bit0=1 and bit2=1, SHALL pulse newCalculation for this cycle only and go to WAIT, else go to ADVANCE with no pulse.
REQ-024 WAIT: calcRdy SHALL be ignored in the ISSUE cycle and sampled only from the first WAIT cycle.
REQ-025 WAIT: when calcRdy=1 and stall=0, SHALL assert resultValid for one cycle and go to ADVANCE; otherwise SHALL hold all outputs stable.
REQ-026 ADVANCE: layerIndex SHALL increment; at NUM_LAYERS-1 it SHALL wrap to 0 and x SHALL increment; at x=HOR_PIX-1, x SHALL wrap to 0 and y SHALL increment.
REQ-027 ADVANCE at layer NUM_LAYERS-1, x=HOR_PIX-1, y=VER_PIX-1: SHALL pulse frameDone, clear counters and go to IDLE; otherwise go to FETCH.
REQ-028 Latency: visible layer SHALL take 3 cycles plus WAIT duration (minimum 4); skipped layer SHALL take exactly 3 cycles.
REQ-029 frameStart while busy=1 SHALL be ignored.
REQ-030 layerRegisters, xPixel, yPixel and layerIndex SHALL be stable from ISSUE through the end of WAIT.
REQ-031 Counters SHALL be unsigned and never exceed HOR_PIX-1, VER_PIX-1 or NUM_LAYERS-1.

Reset
REQ-032 On rst=0, SHALL asynchronously enter IDLE with all outputs and counters 0, including newCalculation, resultValid, frameDone and busy.
REQ-033 Reset mid-frame SHALL abandon the scan; after release, SHALL stay in IDLE until frameStart.

Verification
REQ-034 Reset with all layers vacant, frameStart=1 for one cycle -> no newCalculation; frameDone pulses exactly 3*16*480*272 cycles after the first FETCH.
REQ-035 Layer 5 visible (bits 0,2 set), calcRdy=1 constant, stall=0 -> newCalculation and resultValid pulse once per pixel with layerIndex=5; 4 cycles for that layer.
REQ-036 Layer 0 visible, calcRdy low for 10 WAIT cycles -> outputs held; resultValid on the 11th WAIT cycle.
REQ-037 calcRdy=1 with stall=1 for 3 cycles -> no resultValid until stall=0; layerRegisters is unchanged.
REQ-038 HOR_PIX=4, VER_PIX=2, NUM_LAYERS=2 -> x wraps 3->0, y increments; frameDone is followed by IDLE with busy=0.
REQ-039 rst=0 during WAIT at x=100 -> all outputs 0 immediately; frameStart mid-frame has no effect.
